// File: rtl/dot_reduce_pipe.sv
// Pipelined dot-product reduction: operand register, registered adder tree, multi-beat
// accumulator and a first-word-fall-through result FIFO with credit-based admission.
module dot_reduce_pipe #(
  parameter int unsigned PE_COUNT   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_DEPTH  = 4,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] pe_res,
  input  logic [PE_COUNT-1:0]                 lane_mask,
  input  logic                                in_first,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_sat,
  output logic [$clog2(OUT_DEPTH):0]          out_count
);

  localparam int unsigned Levels    = $clog2(PE_COUNT);
  localparam int unsigned NodeCount = 2 * PE_COUNT - 1;
  localparam int unsigned Root      = NodeCount - 1;
  localparam int unsigned PtrW      = $clog2(OUT_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned ExtW      = ACC_WIDTH - DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] MaxVal =
      {{(ExtW + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MinVal =
      {{(ExtW + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic accept;
  logic push;
  logic pop;

  // Stage 0 holds the masked operands; each later stage holds pairwise sums of the previous.
  logic [Levels:0] vld_q;
  logic [Levels:0] first_q;
  logic [Levels:0] last_q;
  logic signed [ACC_WIDTH-1:0] node_q [NodeCount];

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_sat;

  logic [DATA_WIDTH-1:0] mem_data [OUT_DEPTH];
  logic                  mem_sat  [OUT_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [CntW-1:0]       count_d;
  logic [CntW-1:0]       pending_q;
  logic [CntW-1:0]       pending_d;
  logic [CntW:0]         credits_used;

  assign accept = in_valid && in_ready;

  // Admission control only looks at registered state, so the tree never has to stall.
  assign credits_used = {1'b0, count_q} + {1'b0, pending_q};
  assign in_ready     = credits_used < (CntW + 1)'(OUT_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      vld_q   <= {vld_q[Levels-1:0], accept};
      first_q <= {first_q[Levels-1:0], in_first};
      last_q  <= {last_q[Levels-1:0], in_last};
    end
  end

  for (genvar i = 0; i < PE_COUNT; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (accept) begin
        node_q[i] <= lane_mask[i] ? {{ExtW{pe_res[i][DATA_WIDTH-1]}}, pe_res[i]} : '0;
      end
    end
  end

  for (genvar s = 1; s <= Levels; s++) begin : g_level
    localparam int unsigned Src = 2 * PE_COUNT - 2 * (PE_COUNT >> (s - 1));
    localparam int unsigned Dst = 2 * PE_COUNT - 2 * (PE_COUNT >> s);
    for (genvar i = 0; i < (PE_COUNT >> s); i++) begin : g_node
      always_ff @(posedge clk) begin
        if (vld_q[s-1]) begin
          node_q[Dst+i] <= node_q[Src+2*i] + node_q[Src+2*i+1];
        end
      end
    end
  end

  assign acc_d = first_q[Levels] ? node_q[Root] : acc_q + node_q[Root];
  assign push  = vld_q[Levels] && last_q[Levels];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (vld_q[Levels]) begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    res_data = acc_d[DATA_WIDTH-1:0];
    res_sat  = 1'b0;
    if (SATURATE) begin
      if (acc_d > MaxVal) begin
        res_data = MaxVal[DATA_WIDTH-1:0];
        res_sat  = 1'b1;
      end else if (acc_d < MinVal) begin
        res_data = MinVal[DATA_WIDTH-1:0];
        res_sat  = 1'b1;
      end
    end
  end

  assign pop = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // A last beat holds its credit until the edge it lands in the FIFO, where count takes over.
  always_comb begin
    pending_d = pending_q;
    if (accept && in_last) begin
      pending_d = pending_d + CntW'(1);
    end
    if (push) begin
      pending_d = pending_d - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data[wr_ptr_q] <= res_data;
      mem_sat[wr_ptr_q]  <= res_sat;
    end
  end

  assign out_valid = count_q != '0;
  assign out_count = count_q;
  assign out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
  assign out_sat   = out_valid ? mem_sat[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_dot_reduce_pipe.sv
// Scoreboard bench for dot_reduce_pipe: a behavioural model queues expected results as beats
// are accepted, and a negedge monitor compares them as the FIFO head is consumed.
module tb_dot_reduce_pipe;

  localparam int unsigned PeCount   = 4;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned OutDepth  = 4;

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              in_valid;
  logic                              in_ready;
  logic [PeCount-1:0][DataWidth-1:0] pe_res;
  logic [PeCount-1:0]                lane_mask;
  logic                              in_first;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [DataWidth-1:0]              out_data;
  logic                              out_sat;
  logic [2:0]                        out_count;

  dot_reduce_pipe #(
    .PE_COUNT  (PeCount),
    .DATA_WIDTH(DataWidth),
    .ACC_WIDTH (40),
    .OUT_DEPTH (OutDepth),
    .SATURATE  (1'b1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pe_res   (pe_res),
    .lane_mask(lane_mask),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [32:0]        exp_q [$];
  logic [32:0]        head_exp;
  logic signed [39:0] model_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("count_bound", 64'(out_count <= 3'(OutDepth)), 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_result", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          head_exp = exp_q.pop_front();
          check_eq("result_data", 64'(out_data), 64'(head_exp[31:0]));
          check_eq("result_sat", 64'(out_sat), 64'(head_exp[32]));
        end
      end
    end
  end

  // Drives one beat once in_ready is seen, then updates the model at the acceptance edge.
  task automatic send(input logic [3:0][31:0] v, input logic [3:0] m, input logic f,
                      input logic l);
    int n;
    logic signed [39:0] sum;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check_eq("send_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    pe_res    = v;
    lane_mask = m;
    in_first  = f;
    in_last   = l;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) sum = sum + {{8{v[i][31]}}, v[i]};
    end
    model_acc = f ? sum : model_acc + sum;
    if (l) begin
      if (model_acc > 40'sh00_7FFF_FFFF) exp_q.push_back({1'b1, 32'h7FFF_FFFF});
      else if (model_acc < 40'shFF_8000_0000) exp_q.push_back({1'b1, 32'h8000_0000});
      else exp_q.push_back({1'b0, model_acc[31:0]});
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("drain_count", 64'(out_count), 64'd0);
  endtask

  task automatic wait_count(input int target);
    int n;
    n = 0;
    while (int'(out_count) != target && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("count_reached", 64'(out_count), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    model_acc = '0;
    repeat (2) begin
      in_valid  = 1'($urandom);
      pe_res    = {$urandom, $urandom, $urandom, $urandom};
      lane_mask = 4'($urandom);
      in_first  = 1'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_out_count", 64'(out_count), 64'd0);
    check_eq("reset_in_ready", 64'(in_ready), 64'd1);
    check_eq("reset_out_data", 64'(out_data), 64'd0);
    check_eq("reset_out_sat", 64'(out_sat), 64'd0);

    // Single beat: pushed at edge t+3, first seen on the fourth negedge after acceptance.
    out_ready = 1'b1;
    send({32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 1'b1, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check_eq("single_latency", 64'(lat), 64'd4);
    @(negedge clk);
    check_eq("single_then_empty", 64'(out_valid), 64'd0);
    wait_drain();

    send({32'd1, 32'd1, 32'd1, 32'd1}, 4'b1111, 1'b1, 1'b0);
    send({32'd1, 32'd1, 32'd1, 32'd1}, 4'b0101, 1'b0, 1'b0);
    send({32'd1, 32'd1, 32'd1, 32'd1}, 4'b1111, 1'b0, 1'b1);
    send({32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB}, 4'b1111, 1'b1, 1'b1);
    wait_drain();

    send({4{32'h7FFF_FFFF}}, 4'b1111, 1'b1, 1'b1);
    send({4{32'h8000_0000}}, 4'b1111, 1'b1, 1'b1);
    send({32'd0, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF}, 4'b1111, 1'b1, 1'b1);
    wait_drain();

    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send({32'd0, 32'd0, 32'd0, 32'(k)}, 4'b1111, 1'b1, 1'b1);
    end
    check_eq("bp_ready_drop", 64'(in_ready), 64'd0);
    wait_count(4);
    check_eq("bp_full_ready", 64'(in_ready), 64'd0);
    // A beat offered while not ready must leave no trace.
    pe_res    = {4{32'd99}};
    lane_mask = 4'b1111;
    in_first  = 1'b1;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    check_eq("bp_hold_count", 64'(out_count), 64'd4);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_credit_return", 64'(in_ready), 64'd1);
    check_eq("bp_count_after_pop", 64'(out_count), 64'd3);
    send({32'd0, 32'd0, 32'd0, 32'd5}, 4'b1111, 1'b1, 1'b1);
    check_eq("bp_refull", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send({32'd0, 32'd0, 32'd0, 32'd6}, 4'b1111, 1'b1, 1'b1);
    wait_drain();

    out_ready = 1'b0;
    send({32'd0, 32'd0, 32'd0, 32'd7}, 4'b1111, 1'b1, 1'b1);
    send({32'd0, 32'd0, 32'd0, 32'd7}, 4'b1111, 1'b1, 1'b1);
    wait_count(2);
    send({4{32'd1}}, 4'b1111, 1'b1, 1'b0);
    send({4{32'd1}}, 4'b1111, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_acc = '0;
    check_eq("rst_mid_count", 64'(out_count), 64'd0);
    check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_ready", 64'(in_ready), 64'd1);
    check_eq("rst_mid_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    send({4{32'd2}}, 4'b1111, 1'b1, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
